fifo_wr_arb: RTL and testbench

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_wr_arb.sv | 130 +++++++++++++
 tb/tb_fifo_wr_arb.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter: NREQ producers share one FIFO write port in bursts of BURST_MAX.
// Define FIFO_ARB_STALL_CNT_EN to add the saturating stall_cnt_o counter.
module fifo_wr_arb #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DW        = 8,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ*DW-1:0] din_i,
    output logic [NREQ-1:0]    gnt_o,
    input  logic               fifo_full_i,
    output logic               fifo_write_o,
    output logic [DW-1:0]      fifo_din_o,
`ifdef FIFO_ARB_STALL_CNT_EN
    output logic [15:0]        stall_cnt_o,
`endif
    output logic               busy_o
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   gidx_q, gidx_d;
    logic [3:0]      bcnt_q, bcnt_d;

    logic            granted_req;
    logic            accept;
    logic            stall;
    logic [PW-1:0]   pick;
    logic            pick_vld;

    // gnt_q is all-zero in idle, so these are only ever true while granting.
    assign granted_req = |(gnt_q & req_i);
    assign accept      = granted_req & ~fifo_full_i;
    assign stall       = granted_req & fifo_full_i;

    // First requester strictly after the last served index, wrapping around.
    always_comb begin
        int unsigned idx;
        pick     = ptr_q;
        pick_vld = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!pick_vld && req_i[idx]) begin
                pick_vld = 1'b1;
                pick     = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            ptr_q   <= PW'(NREQ - 1);
            gidx_q  <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            bcnt_q  <= bcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        bcnt_d  = bcnt_q;
        unique case (state_q)
            StIdle: begin
                if (pick_vld) begin
                    state_d = StGrant;
                    gidx_d  = pick;
                    gnt_d   = NREQ'(1) << pick;
                    bcnt_d  = '0;
                end
            end
            StGrant: begin
                if (!granted_req || (accept && (bcnt_q == 4'(BURST_MAX - 1)))) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                    ptr_d   = gidx_q;
                    bcnt_d  = '0;
                end else if (accept) begin
                    bcnt_d = bcnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        gnt_o        = gnt_q;
        busy_o       = (state_q == StGrant);
        fifo_write_o = accept;
        fifo_din_o   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                fifo_din_o = fifo_din_o | din_i[i*DW +: DW];
            end
        end
    end

`ifdef FIFO_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    logic unused_stall;
    assign unused_stall = stall;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: directed scenarios plus randomized traffic against a
// transaction-level arbiter model. Honours FIFO_ARB_STALL_CNT_EN when defined.
module tb_fifo_wr_arb;
    localparam int NREQ      = 4;
    localparam int DW        = 8;
    localparam int BURST_MAX = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*DW-1:0] din;
    logic              full;
    logic [NREQ-1:0]   gnt;
    logic              fwr;
    logic [DW-1:0]     fdin;
    logic              busy;
`ifdef FIFO_ARB_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Arbiter model: who owns the port, who was served last, writes in this burst.
    int m_busy, m_owner, m_ptr, m_bcnt, m_stall;

    always #5 clk = ~clk;

    fifo_wr_arb #(
        .NREQ      (NREQ),
        .DW        (DW),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req),
        .din_i        (din),
        .gnt_o        (gnt),
        .fifo_full_i  (full),
        .fifo_write_o (fwr),
        .fifo_din_o   (fdin),
`ifdef FIFO_ARB_STALL_CNT_EN
        .stall_cnt_o  (stall_cnt),
`endif
        .busy_o       (busy)
    );

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_ptr   = NREQ - 1;
        m_bcnt  = 0;
        m_stall = 0;
    endtask

    task automatic model_edge();
        bit found;
        if (!rst_n) begin
            model_reset();
        end else if (m_busy == 0) begin
            found = 0;
            for (int k = 1; k <= NREQ; k++) begin
                if (!found && req[(m_ptr + k) % NREQ]) begin
                    found   = 1;
                    m_owner = (m_ptr + k) % NREQ;
                end
            end
            if (found) begin
                m_busy = 1;
                m_bcnt = 0;
            end
        end else if (!req[m_owner]) begin
            m_busy = 0;
            m_ptr  = m_owner;
            m_bcnt = 0;
        end else if (full) begin
            if (m_stall < 65535) m_stall++;
        end else begin
            m_bcnt++;
            if (m_bcnt == BURST_MAX) begin
                m_busy = 0;
                m_ptr  = m_owner;
                m_bcnt = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'hF;
        full  = 1'b0;
        din   = 32'hD3C2_B1A0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (gnt !== 4'b0) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++;
        if (fwr !== 1'b0) begin n_fail++; $display("FAIL reset_write got=%b exp=0", fwr); end
        n_checks++;
        if (fdin !== 8'h00) begin n_fail++; $display("FAIL reset_din got=%h exp=00", fdin); end
`ifdef FIFO_ARB_STALL_CNT_EN
        n_checks++;
        if (stall_cnt !== 16'h0) begin
            n_fail++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt);
        end
`endif
    endtask

    // All four requesting: 4-write bursts in order 0,1,2,3,0 with a dead cycle in between.
    task automatic test_round_robin();
        logic [3:0] eg;
        logic [7:0] ed;
        rst_n = 1'b1;
        for (int c = 0; c < 26; c++) begin
            eg = (c % 5 == 0) ? 4'b0 : 4'(1 << ((c / 5) % 4));
            ed = (c % 5 == 0) ? 8'h00 : din[((c / 5) % 4)*DW +: DW];
            #1;
            n_checks++;
            if (gnt !== eg) begin n_fail++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, gnt, eg); end
            n_checks++;
            if (fwr !== (eg != 0)) begin
                n_fail++; $display("FAIL rr_write c=%0d got=%b exp=%b", c, fwr, eg != 0);
            end
            n_checks++;
            if (fdin !== ed) begin n_fail++; $display("FAIL rr_din c=%0d got=%h exp=%h", c, fdin, ed); end
            n_checks++;
            if (busy !== (eg != 0)) begin
                n_fail++; $display("FAIL rr_busy c=%0d got=%b exp=%b", c, busy, eg != 0);
            end
            tick();
        end
        req = 4'b0;
        tick();
    endtask

    // Producer 2 drops its request after two writes; the grant ends and the pointer lands on 2.
    task automatic test_short_burst();
        req = 4'b0100;
        #1;
        n_checks++;
        if (gnt !== 4'b0) begin n_fail++; $display("FAIL short_idle got=%b exp=0000", gnt); end
        tick();
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if (gnt !== 4'b0100) begin n_fail++; $display("FAIL short_gnt got=%b exp=0100", gnt); end
            n_checks++;
            if (fwr !== 1'b1) begin n_fail++; $display("FAIL short_write got=%b exp=1", fwr); end
            n_checks++;
            if (fdin !== 8'hC2) begin n_fail++; $display("FAIL short_din got=%h exp=c2", fdin); end
            tick();
        end
        req = 4'b0;
        #1;
        n_checks++;
        if (fwr !== 1'b0) begin n_fail++; $display("FAIL short_nowrite got=%b exp=0", fwr); end
        tick();
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL short_release got=%b exp=0", busy); end
        req = 4'hF;
        tick();
        #1;
        n_checks++;
        if (gnt !== 4'b1000) begin n_fail++; $display("FAIL short_ptr got=%b exp=1000", gnt); end
        req = 4'b0;
        tick();
    endtask

    // FIFO full for three cycles mid-burst: grant held, no writes, burst still totals four.
    task automatic test_stall();
        int writes = 0;
        logic [3:0] eg;
        req = 4'b0010;
        tick();
        for (int c = 0; c < 8; c++) begin
            full = (c >= 2 && c <= 4);
            if (c == 7) req = 4'b0;
            eg = (c < 7) ? 4'b0010 : 4'b0;
            #1;
            n_checks++;
            if (gnt !== eg) begin n_fail++; $display("FAIL stall_gnt c=%0d got=%b exp=%b", c, gnt, eg); end
            n_checks++;
            if (fwr !== (c < 7 && !full)) begin
                n_fail++; $display("FAIL stall_write c=%0d got=%b exp=%b", c, fwr, c < 7 && !full);
            end
            if (fwr === 1'b1) writes++;
            tick();
        end
        full = 1'b0;
        n_checks++;
        if (writes != 4) begin n_fail++; $display("FAIL stall_writes got=%0d exp=4", writes); end
`ifdef FIFO_ARB_STALL_CNT_EN
        n_checks++;
        if (stall_cnt !== 16'd3) begin
            n_fail++; $display("FAIL stall_cnt got=%0d exp=3", stall_cnt);
        end
`endif
    endtask

    // With the pointer on 0 and producers 0 and 3 requesting, 3 goes first, then 0.
    task automatic test_pattern_1001();
        logic [3:0] eg;
        req = 4'b0001;
        tick();
        req = 4'b0;
        tick();
        req = 4'b1001;
        for (int c = 0; c < 11; c++) begin
            eg = (c >= 1 && c <= 4) ? 4'b1000 : (c >= 6 && c <= 9) ? 4'b0001 : 4'b0000;
            #1;
            n_checks++;
            if (gnt !== eg) begin n_fail++; $display("FAIL p1001_gnt c=%0d got=%b exp=%b", c, gnt, eg); end
            tick();
        end
        req = 4'b0;
        tick();
    endtask

    // Reset dropped during the second write clears everything before the next edge.
    task automatic test_async_reset();
        req = 4'hF;
        tick();
        tick();
        #1;
        n_checks++;
        if (fwr !== 1'b1) begin n_fail++; $display("FAIL arst_pre_write got=%b exp=1", fwr); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (gnt !== 4'b0) begin n_fail++; $display("FAIL arst_gnt got=%b exp=0000", gnt); end
        n_checks++;
        if (fwr !== 1'b0) begin n_fail++; $display("FAIL arst_write got=%b exp=0", fwr); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy got=%b exp=0", busy); end
        tick();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (gnt !== 4'b0) begin n_fail++; $display("FAIL arst_release got=%b exp=0000", gnt); end
        tick();
        #1;
        n_checks++;
        if (gnt !== 4'b0001) begin n_fail++; $display("FAIL arst_first got=%b exp=0001", gnt); end
        req = 4'b0;
        tick();
    endtask

    // Three producers fill an 8-entry FIFO that is never drained.
    task automatic test_fifo_fill();
        int cnt = 0;
        logic w;
        req = 4'b0111;
        for (int c = 0; c < 40; c++) begin
            full = (cnt >= 8);
            #1;
            n_checks++;
            if (fwr === 1'b1 && full) begin
                n_fail++; $display("FAIL fill_write_while_full c=%0d got=1 exp=0", c);
            end
            w = fwr;
            @(posedge clk);
            if (w === 1'b1) cnt++;
            n_checks++;
            if (cnt > 8) begin n_fail++; $display("FAIL fill_overflow got=%0d exp<=8", cnt); end
            #1;
        end
        n_checks++;
        if (cnt != 8) begin n_fail++; $display("FAIL fill_count got=%0d exp=8", cnt); end
        n_checks++;
        if (gnt !== 4'b0001) begin n_fail++; $display("FAIL fill_held_gnt got=%b exp=0001", gnt); end
        req  = 4'b0;
        full = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_random();
        logic [3:0] eg;
        logic       ew;
        logic [7:0] ed;
        rst_n = 1'b0;
        req   = 4'b0;
        full  = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            full  = ($urandom_range(0, 4) == 0);
            din   = $urandom;
            rst_n = ($urandom_range(0, 199) != 0);
            #1;
            eg = (rst_n && m_busy != 0) ? 4'(1 << m_owner) : 4'b0;
            ew = rst_n && (m_busy != 0) && req[m_owner] && !full;
            ed = (eg != 0) ? din[m_owner*DW +: DW] : 8'h00;
            n_checks++;
            if (gnt !== eg) begin n_fail++; $display("FAIL rand_gnt c=%0d got=%b exp=%b", c, gnt, eg); end
            n_checks++;
            if (fwr !== ew) begin n_fail++; $display("FAIL rand_write c=%0d got=%b exp=%b", c, fwr, ew); end
            n_checks++;
            if (fdin !== ed) begin n_fail++; $display("FAIL rand_din c=%0d got=%h exp=%h", c, fdin, ed); end
            n_checks++;
            if (busy !== (eg != 0)) begin
                n_fail++; $display("FAIL rand_busy c=%0d got=%b exp=%b", c, busy, eg != 0);
            end
`ifdef FIFO_ARB_STALL_CNT_EN
            n_checks++;
            if (stall_cnt !== 16'(m_stall)) begin
                n_fail++; $display("FAIL rand_stall_cnt c=%0d got=%0d exp=%0d", c, stall_cnt, m_stall);
            end
`endif
            model_edge();
            tick();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_short_burst();
        test_stall();
        test_pattern_1001();
        test_async_reset();
        test_fifo_fill();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
